// File: rtl/regfile_read_arbiter.sv
// Arbitrates the single register_file read port between the CPU decode stage and the
// display register scanner; CPU has priority, a starvation counter guarantees display progress.
module regfile_read_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              rf_we,
    input  logic [ADDR_W-1:0] rf_wa,
    input  logic [DATA_W-1:0] rf_wd,
    output logic              disp_starved
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        PRI_CPU  = 1'b0,
        PRI_DISP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
    logic               cpu_rvalid_q, cpu_rvalid_d;
    logic               disp_rvalid_q, disp_rvalid_d;
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]  disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0]  resp_data;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q       <= PRI_CPU;
            wait_cnt_q    <= '0;
            rf_addr_q     <= '0;
            cpu_rvalid_q  <= 1'b0;
            disp_rvalid_q <= 1'b0;
            cpu_rdata_q   <= '0;
            disp_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            rf_addr_q     <= rf_addr_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
            disp_rvalid_q <= disp_rvalid_d;
            cpu_rdata_q   <= cpu_rdata_d;
            disp_rdata_q  <= disp_rdata_d;
        end
    end

    // Switch to display priority on the edge where the counter reaches MAX_WAIT,
    // so the display is granted at most MAX_WAIT+1 cycles after requesting.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (disp_gnt || !disp_req) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        case (state_q)
            PRI_CPU: begin
                if (wait_cnt_d == CNT_W'(MAX_WAIT)) begin
                    state_d = PRI_DISP;
                end
            end
            PRI_DISP: begin
                if (disp_gnt || !disp_req) begin
                    state_d = PRI_CPU;
                end
            end
            default: state_d = PRI_CPU;
        endcase
    end

    // Grants are suppressed while reset is held so no request is accepted.
    always_comb begin
        cpu_gnt      = 1'b0;
        disp_gnt     = 1'b0;
        disp_starved = (state_q == PRI_DISP);
        if (!reset) begin
            if (state_q == PRI_DISP) begin
                disp_gnt = disp_req;
                cpu_gnt  = cpu_req && !disp_req;
            end else begin
                cpu_gnt  = cpu_req;
                disp_gnt = disp_req && !cpu_req;
            end
        end
    end

    always_comb begin
        rf_addr_d = rf_addr_q;
        if (cpu_gnt) begin
            rf_addr_d = cpu_addr;
        end else if (disp_gnt) begin
            rf_addr_d = disp_addr;
        end
        rf_addr = rf_addr_d;
    end

    // R0 reads as zero even when a write to it is in flight.
    always_comb begin
        if (rf_addr == ADDR_W'(0)) begin
            resp_data = '0;
        end else if (rf_we && (rf_wa == rf_addr)) begin
            resp_data = rf_wd;
        end else begin
            resp_data = rf_rdata;
        end
    end

    always_comb begin
        cpu_rvalid_d  = cpu_gnt;
        disp_rvalid_d = disp_gnt;
        cpu_rdata_d   = cpu_gnt  ? resp_data : cpu_rdata_q;
        disp_rdata_d  = disp_gnt ? resp_data : disp_rdata_q;
    end

    assign cpu_rvalid  = cpu_rvalid_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Scoreboard bench for regfile_read_arbiter: a reference arbitration model predicts grants and
// pushes expected read data, which is popped and compared when the DUT returns rvalid.
module tb_regfile_read_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int MAX_WAIT = 4;

    logic              CLOCK_50;
    logic              reset;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic              disp_starved;

    int checkCount = 0;
    int passCount  = 0;

    logic [DATA_W-1:0] cpuQ[$];
    logic [DATA_W-1:0] dispQ[$];
    logic [DATA_W-1:0] expCpuLast;
    logic [DATA_W-1:0] expDispLast;
    logic              mState;
    int                mWait;
    logic [ADDR_W-1:0] mRfAddr;
    logic              mCpuGnt;
    logic              mDispGnt;

    regfile_read_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .rf_addr     (rf_addr),
        .rf_rdata    (rf_rdata),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .disp_starved(disp_starved)
    );

    // Register file stand-in: register n reads as 32'hAAAA000n.
    assign rf_rdata = {16'hAAAA, 13'd0, rf_addr};

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] expectedData(input logic [ADDR_W-1:0] a, input logic we,
                                                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        if (a == '0) return '0;
        if (we && wa == a) return wd;
        return {16'hAAAA, 13'd0, a};
    endfunction

    task automatic checkResponses();
        checkOutput("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, cpuQ.size() != 0});
        if (cpuQ.size() != 0) expCpuLast = cpuQ.pop_front();
        checkOutput("cpu_rdata", cpu_rdata, expCpuLast);
        checkOutput("disp_rvalid", {31'd0, disp_rvalid}, {31'd0, dispQ.size() != 0});
        if (dispQ.size() != 0) expDispLast = dispQ.pop_front();
        checkOutput("disp_rdata", disp_rdata, expDispLast);
    endtask

    task automatic applyStimulus(input logic creq, input logic [ADDR_W-1:0] caddr,
                                 input logic dreq, input logic [ADDR_W-1:0] daddr,
                                 input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        @(negedge CLOCK_50);
        checkResponses();
        cpu_req   = creq;
        cpu_addr  = caddr;
        disp_req  = dreq;
        disp_addr = daddr;
        rf_we     = we;
        rf_wa     = wa;
        rf_wd     = wd;
        #1;
        if (mState) begin
            mDispGnt = dreq;
            mCpuGnt  = creq && !dreq;
        end else begin
            mCpuGnt  = creq;
            mDispGnt = dreq && !creq;
        end
        checkOutput("disp_starved", {31'd0, disp_starved}, {31'd0, mState});
        checkOutput("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, mCpuGnt});
        checkOutput("disp_gnt", {31'd0, disp_gnt}, {31'd0, mDispGnt});
        if (mCpuGnt) mRfAddr = caddr;
        else if (mDispGnt) mRfAddr = daddr;
        checkOutput("rf_addr", {29'd0, rf_addr}, {29'd0, mRfAddr});
        if (mCpuGnt) cpuQ.push_back(expectedData(mRfAddr, we, wa, wd));
        if (mDispGnt) dispQ.push_back(expectedData(mRfAddr, we, wa, wd));
        if (mDispGnt || !dreq) mWait = 0;
        else if (mWait < MAX_WAIT) mWait++;
        if (!mState) mState = (mWait == MAX_WAIT);
        else mState = !(mDispGnt || !dreq);
    endtask

    task automatic resetModel();
        cpuQ.delete();
        dispQ.delete();
        expCpuLast  = '0;
        expDispLast = '0;
        mState      = 1'b0;
        mWait       = 0;
        mRfAddr     = '0;
    endtask

    initial begin
        logic              cReq, dReq, cPend, dPend, we;
        logic [ADDR_W-1:0] cAddr, dAddr, wa;
        logic [DATA_W-1:0] wd;

        reset = 1'b1;
        cpu_req = 1'b1; cpu_addr = 3'd4;
        disp_req = 1'b1; disp_addr = 3'd5;
        rf_we = 1'b0; rf_wa = '0; rf_wd = '0;
        resetModel();
        repeat (2) @(negedge CLOCK_50);
        checkOutput("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        checkOutput("rst_disp_gnt", {31'd0, disp_gnt}, 32'd0);
        checkOutput("rst_rf_addr", {29'd0, rf_addr}, 32'd0);
        checkOutput("rst_starved", {31'd0, disp_starved}, 32'd0);
        checkResponses();
        cpu_req = 1'b0; disp_req = 1'b0;
        reset = 1'b0;

        // Reset landing on the cycle the CPU response would appear
        applyStimulus(1, 3, 0, 0, 0, 0, 0);
        @(posedge CLOCK_50);
        #1 reset = 1'b1;
        #1;
        resetModel();
        checkOutput("midrst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        checkOutput("midrst_cpu_rdata", cpu_rdata, 32'd0);
        checkOutput("midrst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        checkOutput("midrst_rf_addr", {29'd0, rf_addr}, 32'd0);
        checkOutput("midrst_starved", {31'd0, disp_starved}, 32'd0);
        cpu_req = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b0;

        // Single CPU read, then simultaneous requests
        applyStimulus(1, 3, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Starvation: continuous CPU traffic, display waiting on R5
        for (int i = 0; i < MAX_WAIT + 1; i++) applyStimulus(1, 3'(i + 1), 1, 5, 0, 0, 0);
        applyStimulus(1, 7, 0, 0, 0, 0, 0);
        applyStimulus(1, 2, 1, 4, 0, 0, 0);
        applyStimulus(0, 0, 1, 4, 0, 0, 0);

        // Write bypass and R0 rule
        applyStimulus(1, 6, 0, 0, 1, 6, 32'h12345678);
        applyStimulus(0, 0, 1, 0, 1, 0, 32'hFFFFFFFF);
        applyStimulus(1, 4, 0, 0, 1, 5, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Random traffic honouring the hold-address-until-granted rule
        cPend = 1'b0; dPend = 1'b0;
        cReq = 1'b0; dReq = 1'b0; cAddr = '0; dAddr = '0;
        for (int i = 0; i < 80; i++) begin
            if (!cPend) begin
                cReq  = ($urandom_range(0, 3) != 0);
                cAddr = ADDR_W'($urandom_range(0, 7));
            end
            if (!dPend) begin
                dReq  = ($urandom_range(0, 1) != 0);
                dAddr = ADDR_W'($urandom_range(0, 7));
            end
            we = ($urandom_range(0, 1) != 0);
            wa = ADDR_W'($urandom_range(0, 7));
            wd = $urandom;
            applyStimulus(cReq, cAddr, dReq, dAddr, we, wa, wd);
            cPend = cReq && !mCpuGnt;
            dPend = dReq && !mDispGnt;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
